irq_controller: RTL and testbench

Memory-mapped interrupt controller between the bus peripherals (timer at 0xF0, mouse, etc.) and the processor's interrupt input. It captures level interrupt requests from up to four sources, acknowledges each source, and holds the requests in a pending register. It applies a per-source mask and fixed priority, then presents a single raise/ack handshake and a readable vector to the processor.

---
 rtl/irq_ctrl_pkg.sv | 19 +
 rtl/irq_prio_enc.sv | 24 ++
 rtl/irq_controller.sv | 137 +++++++++++++
 tb/tb_irq_controller.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg
// Shared definitions for the interrupt controller: source count, register
// window offsets and the processor-handshake state encoding.
package irq_ctrl_pkg;

    localparam int NUM_SOURCES = 4;

    localparam logic [7:0] OFF_STATUS = 8'd0;
    localparam logic [7:0] OFF_MASK   = 8'd1;
    localparam logic [7:0] OFF_VECTOR = 8'd2;
    localparam logic [7:0] OFF_CLEAR  = 8'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc
// Combinational fixed-priority encoder: returns the lowest set request index
// (index 0 wins).
//   req   : per-source request vector
//   idx   : index of the winning request (0 when none)
//   valid : at least one request is set
module irq_prio_enc
    import irq_ctrl_pkg::*;
(
    input  logic [NUM_SOURCES-1:0] req,
    output logic [1:0]             idx,
    output logic                   valid
);

    always_comb begin
        valid = |req;
        idx   = 2'd0;
        if (req[0])      idx = 2'd0;
        else if (req[1]) idx = 2'd1;
        else if (req[2]) idx = 2'd2;
        else if (req[3]) idx = 2'd3;
    end

endmodule

// File: rtl/irq_controller.sv
// irq_controller
// Captures level interrupt requests from four sources, acknowledges each one,
// keeps them in a pending register and presents the highest-priority unmasked
// request to the processor through a raise/ack handshake.
//   CLK, RESET     : system clock, synchronous active-high reset
//   BUS_DATA       : shared data bus, driven only for registered reads
//   BUS_ADDR/WE    : bus address and write enable
//   SRC_RAISE/ACK  : per-source level request and one-cycle acknowledge
//   CPU_INT_RAISE  : interrupt request to the processor
//   CPU_INT_ACK    : processor acknowledge (pulse or level)
//
// state  | meaning
// IDLE   | waiting for an unmasked pending request
// ASSERT | vector latched, CPU_INT_RAISE held until CPU_INT_ACK
// GAP    | one forced low cycle before the next raise
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter logic [7:0] BaseAddr    = 8'hE0,
    parameter logic [3:0] InitialMask = 4'hF
) (
    input  logic                   CLK,
    input  logic                   RESET,
    inout  wire  [7:0]             BUS_DATA,
    input  logic [7:0]             BUS_ADDR,
    input  logic                   BUS_WE,
    input  logic [NUM_SOURCES-1:0] SRC_RAISE,
    output logic [NUM_SOURCES-1:0] SRC_ACK,
    output logic                   CPU_INT_RAISE,
    input  logic                   CPU_INT_ACK
);

    logic [NUM_SOURCES-1:0] pending_q, pending_d;
    logic [NUM_SOURCES-1:0] overrun_q, overrun_d;
    logic [NUM_SOURCES-1:0] ack_q, ack_d;
    logic [NUM_SOURCES-1:0] mask_q, mask_d;
    logic [1:0]             vector_q, vector_d;
    logic                   in_svc_q, in_svc_d;
    logic                   raise_q, raise_d;
    irq_state_e             state_q, state_d;
    logic                   bus_oe_q, bus_oe_d;
    logic [7:0]             bus_rdata_q, bus_rdata_d;

    logic                   sel_status, sel_mask, sel_vector, sel_clear;
    logic [NUM_SOURCES-1:0] capture, cpu_clear;
    logic [7:0]             wr_clear;
    logic [1:0]             prio_idx;
    logic                   prio_valid;

    irq_prio_enc u_prio (
        .req   (pending_q & mask_q),
        .idx   (prio_idx),
        .valid (prio_valid)
    );

    always_comb begin
        sel_status = (BUS_ADDR == BaseAddr + OFF_STATUS);
        sel_mask   = (BUS_ADDR == BaseAddr + OFF_MASK);
        sel_vector = (BUS_ADDR == BaseAddr + OFF_VECTOR);
        sel_clear  = (BUS_ADDR == BaseAddr + OFF_CLEAR);

        // A source is captured once per raise; ack_q blocks the cycle in
        // which the source is still dropping its level.
        capture  = SRC_RAISE & ~ack_q;
        wr_clear = (BUS_WE && sel_clear) ? BUS_DATA : 8'h00;

        cpu_clear = '0;
        if (state_q == ASSERT && CPU_INT_ACK) cpu_clear[vector_q] = 1'b1;

        // Captures are ORed in last so a same-cycle set beats any clear.
        pending_d = (pending_q & ~(wr_clear[3:0] | cpu_clear)) | capture;
        overrun_d = (overrun_q & ~wr_clear[7:4]) | (capture & pending_q);
        ack_d     = capture;
        mask_d    = (BUS_WE && sel_mask) ? BUS_DATA[3:0] : mask_q;

        bus_oe_d    = !BUS_WE && (sel_status || sel_mask || sel_vector);
        bus_rdata_d = 8'h00;
        if (sel_status)      bus_rdata_d = {overrun_q, pending_q};
        else if (sel_mask)   bus_rdata_d = {4'h0, mask_q};
        else if (sel_vector) bus_rdata_d = {in_svc_q, 5'b0, vector_q};

        state_d  = state_q;
        vector_d = vector_q;
        in_svc_d = in_svc_q;
        raise_d  = raise_q;
        case (state_q)
            IDLE: begin
                if (prio_valid) begin
                    vector_d = prio_idx;
                    in_svc_d = 1'b1;
                    raise_d  = 1'b1;
                    state_d  = ASSERT;
                end
            end
            ASSERT: begin
                if (CPU_INT_ACK) begin
                    in_svc_d = 1'b0;
                    raise_d  = 1'b0;
                    state_d  = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pending_q   <= '0;
            overrun_q   <= '0;
            ack_q       <= '0;
            mask_q      <= InitialMask;
            vector_q    <= 2'd0;
            in_svc_q    <= 1'b0;
            raise_q     <= 1'b0;
            state_q     <= IDLE;
            bus_oe_q    <= 1'b0;
            bus_rdata_q <= 8'h00;
        end else begin
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            ack_q       <= ack_d;
            mask_q      <= mask_d;
            vector_q    <= vector_d;
            in_svc_q    <= in_svc_d;
            raise_q     <= raise_d;
            state_q     <= state_d;
            bus_oe_q    <= bus_oe_d;
            bus_rdata_q <= bus_rdata_d;
        end
    end

    assign SRC_ACK       = ack_q;
    assign CPU_INT_RAISE = raise_q;
    assign BUS_DATA      = bus_oe_q ? bus_rdata_q : 8'hzz;

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

    localparam logic [7:0] BASE = 8'hE0;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] BUS_ADDR;
    logic       BUS_WE;
    logic [3:0] SRC_RAISE;
    wire  [3:0] SRC_ACK;
    wire        CPU_INT_RAISE;
    logic       CPU_INT_ACK;
    logic       tb_drv;
    logic [7:0] tb_wdata;
    wire  [7:0] BUS_DATA;

    assign BUS_DATA = tb_drv ? tb_wdata : 8'hzz;

    always #5 CLK = ~CLK;

    irq_controller #(.BaseAddr(8'hE0), .InitialMask(4'hF)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .BUS_DATA      (BUS_DATA),
        .BUS_ADDR      (BUS_ADDR),
        .BUS_WE        (BUS_WE),
        .SRC_RAISE     (SRC_RAISE),
        .SRC_ACK       (SRC_ACK),
        .CPU_INT_RAISE (CPU_INT_RAISE),
        .CPU_INT_ACK   (CPU_INT_ACK)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0 = waiting, 1 = presenting to CPU, 2 = gap.
    bit [3:0] m_pend = 0, m_ovr = 0, m_ack = 0, m_mask = 4'hF;
    bit [1:0] m_vec = 0;
    int       m_phase = 0;
    bit       m_raise = 0, m_drive = 0;
    bit [7:0] m_rdata = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit [3:0] cap, clr, oclr, en;
        int pick;
        if (RESET) begin
            m_pend = 0; m_ovr = 0; m_ack = 0; m_mask = 4'hF;
            m_vec = 0; m_phase = 0; m_raise = 0; m_drive = 0; m_rdata = 0;
        end else begin
            cap  = SRC_RAISE & ~m_ack;
            clr  = 4'h0;
            oclr = 4'h0;
            if (BUS_WE && BUS_ADDR == BASE + 8'd3) begin
                clr  = tb_wdata[3:0];
                oclr = tb_wdata[7:4];
            end
            m_drive = 0;
            m_rdata = 0;
            if (!BUS_WE) begin
                if (BUS_ADDR == BASE) begin
                    m_drive = 1; m_rdata = {m_ovr, m_pend};
                end else if (BUS_ADDR == BASE + 8'd1) begin
                    m_drive = 1; m_rdata = {4'h0, m_mask};
                end else if (BUS_ADDR == BASE + 8'd2) begin
                    m_drive = 1; m_rdata = {(m_phase == 1), 5'b0, m_vec};
                end
            end
            en = m_pend & m_mask;
            if (m_phase == 0) begin
                if (en != 0) begin
                    pick = 0;
                    while (!en[pick]) pick++;
                    m_vec   = 2'(pick);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (CPU_INT_ACK) begin
                    clr[m_vec] = 1'b1;
                    m_phase    = 2;
                end
            end else begin
                m_phase = 0;
            end
            for (int i = 0; i < 4; i++) begin
                if (cap[i]) begin
                    if (m_pend[i]) m_ovr[i] = 1'b1;
                    else if (oclr[i]) m_ovr[i] = 1'b0;
                    m_pend[i] = 1'b1;
                end else begin
                    if (oclr[i]) m_ovr[i] = 1'b0;
                    if (clr[i]) m_pend[i] = 1'b0;
                end
            end
            if (BUS_WE && BUS_ADDR == BASE + 8'd1) m_mask = tb_wdata[3:0];
            m_ack   = cap;
            m_raise = (m_phase == 1);
        end
    endtask

    task automatic check_outputs();
        chk("src_ack", {4'h0, SRC_ACK}, {4'h0, m_ack});
        chk("cpu_raise", {7'h0, CPU_INT_RAISE}, {7'h0, m_raise});
        chk("bus_oe", {7'h0, dut.bus_oe_q}, {7'h0, m_drive});
        if (m_drive) chk("bus_rdata", BUS_DATA, m_rdata);
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check_outputs();
        @(negedge CLK);
    endtask

    task automatic bus_idle();
        BUS_ADDR = 8'h00; BUS_WE = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a);
        BUS_ADDR = a; BUS_WE = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        BUS_ADDR = a; BUS_WE = 1'b1; tb_drv = 1'b1; tb_wdata = d;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        RESET = 1'b1; SRC_RAISE = 4'h0; CPU_INT_ACK = 1'b0; tb_wdata = 8'h00;
        bus_idle();
        @(negedge CLK);
        step(); step();
        chk("rst_src_ack", {4'h0, SRC_ACK}, 8'h00);
        chk("rst_raise", {7'h0, CPU_INT_RAISE}, 8'h00);
        RESET = 1'b0;

        // timer path
        SRC_RAISE = 4'b0001; step();
        chk("t_ack_hi", {4'h0, SRC_ACK}, 8'h01);
        chk("t_raise_early", {7'h0, CPU_INT_RAISE}, 8'h00);
        SRC_RAISE = 4'b0000; step();
        chk("t_ack_lo", {4'h0, SRC_ACK}, 8'h00);
        chk("t_raise", {7'h0, CPU_INT_RAISE}, 8'h01);
        bus_read(BASE + 8'd2); step();
        chk("t_vector", BUS_DATA, 8'h80);
        bus_read(BASE); step();
        chk("t_status", BUS_DATA, 8'h01);
        bus_idle(); step();
        CPU_INT_ACK = 1'b1; step();
        chk("t_ack_drop", {7'h0, CPU_INT_RAISE}, 8'h00);
        CPU_INT_ACK = 1'b0; bus_read(BASE); step();
        chk("t_pend_clr", BUS_DATA, 8'h00);
        bus_idle(); step();

        // priority
        SRC_RAISE = 4'b1010; step();
        chk("p_ack", {4'h0, SRC_ACK}, 8'h0A);
        SRC_RAISE = 4'b0000; step();
        chk("p_raise1", {7'h0, CPU_INT_RAISE}, 8'h01);
        bus_read(BASE + 8'd2); step();
        chk("p_vec1", BUS_DATA, 8'h81);
        bus_idle(); step();
        CPU_INT_ACK = 1'b1; step();
        chk("p_drop", {7'h0, CPU_INT_RAISE}, 8'h00);
        CPU_INT_ACK = 1'b0; step();
        chk("p_gap_low", {7'h0, CPU_INT_RAISE}, 8'h00);
        step();
        chk("p_raise2", {7'h0, CPU_INT_RAISE}, 8'h01);
        bus_read(BASE + 8'd2); step();
        chk("p_vec2", BUS_DATA, 8'h83);
        bus_idle(); step();
        CPU_INT_ACK = 1'b1; step();
        CPU_INT_ACK = 1'b0; step(); step();

        // mask
        bus_write(BASE + 8'd1, 8'h0E); step();
        bus_idle();
        SRC_RAISE = 4'b0001; step();
        chk("m_ack", {4'h0, SRC_ACK}, 8'h01);
        SRC_RAISE = 4'b0000; step(); step(); step();
        chk("m_no_raise", {7'h0, CPU_INT_RAISE}, 8'h00);
        bus_read(BASE); step();
        chk("m_pend", BUS_DATA, 8'h01);
        bus_idle(); step();
        bus_write(BASE + 8'd1, 8'h0F); step();
        bus_idle(); step();
        chk("m_raise", {7'h0, CPU_INT_RAISE}, 8'h01);
        CPU_INT_ACK = 1'b1; step();
        CPU_INT_ACK = 1'b0; step(); step();

        // overrun and clear
        SRC_RAISE = 4'b0100; step();
        SRC_RAISE = 4'b0000; step();
        SRC_RAISE = 4'b0100; step();
        SRC_RAISE = 4'b0000; step();
        bus_read(BASE); step();
        chk("o_status", BUS_DATA, 8'h44);
        bus_idle(); step();
        bus_write(BASE + 8'd3, 8'h40); step();
        bus_read(BASE); step();
        chk("o_clear", BUS_DATA, 8'h04);
        bus_idle(); step();
        bus_write(BASE + 8'd3, 8'h04); SRC_RAISE = 4'b0100; step();
        SRC_RAISE = 4'b0000; bus_read(BASE); step();
        chk("o_set_wins", BUS_DATA & 8'h0F, 8'h04);
        bus_idle(); step();

        // reset mid-ASSERT
        chk("r_pre_raise", {7'h0, CPU_INT_RAISE}, 8'h01);
        RESET = 1'b1; step();
        chk("r_src_ack", {4'h0, SRC_ACK}, 8'h00);
        chk("r_raise", {7'h0, CPU_INT_RAISE}, 8'h00);
        RESET = 1'b0; bus_read(BASE); step();
        chk("r_status", BUS_DATA, 8'h00);
        bus_read(BASE + 8'd1); step();
        chk("r_mask", BUS_DATA, 8'h0F);
        bus_idle(); step();
        chk("r_bus_released", {7'h0, dut.bus_oe_q}, 8'h00);

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (SRC_RAISE[i]) begin
                    if (SRC_ACK[i] && $urandom_range(3) != 0) SRC_RAISE[i] = 1'b0;
                end else if ($urandom_range(7) == 0) begin
                    SRC_RAISE[i] = 1'b1;
                end
            end
            CPU_INT_ACK = CPU_INT_RAISE ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
            RESET = ($urandom_range(149) == 0);
            r = int'($urandom_range(99));
            if (m_drive && r >= 70) r = r - 35;
            if (r < 35)      bus_idle();
            else if (r < 70) bus_read(BASE + 8'($urandom_range(4)));
            else if (r < 85) bus_write(BASE + 8'd1, 8'($urandom));
            else             bus_write(BASE + 8'd3, 8'($urandom));
            step();
        end
        RESET = 1'b0;
        bus_idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
